// File: rtl/instr_fetch_unit.sv
// Purpose: owns PC and IR, fetches instruction words over imem req/ack, decodes IR fields, applies redirects.
// Latency: imem_ack N cycles after imem_req rises gives instr_valid N+1 cycles after imem_req.
// Backpressure: imem_req is held with a stable address until ack; fetch_busy stalls the sequencer meanwhile.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pc_write,
  input  logic              pc_source,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [31:0]       imm_sext,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              fetch_fault
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {BOOT, REQ, IDLE, FAULT} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] fetch_addr;
  logic              redirect;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] pc_next;

  // Field split and address arithmetic straight off IR and pc (wraps mod 2^ADDR_W)
  assign instr         = ir;
  assign opcode        = ir[31:27];
  assign rd            = ir[26:24];
  assign rs1           = ir[23:21];
  assign rs2           = ir[20:18];
  assign imm_sext      = {{16{ir[15]}}, ir[15:0]};
  assign branch_off    = ADDR_W'($signed(ir[15:0])) << 2;
  assign pc_plus4      = pc + ADDR_W'(4);
  assign branch_target = pc + branch_off;
  assign pc_next       = pc_source ? branch_target : pc_plus4;
  assign imem_addr     = fetch_addr;
  assign fetch_busy    = (state == REQ);

  // Fetch FSM; inside REQ, imem_req=0 marks the one-cycle gap before a re-issued request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ir          <= '0;
      fetch_addr  <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      redirect    <= 1'b0;
      tcnt        <= '0;
    end else begin
      case (state)
        BOOT: begin
          // ack is deliberately not sampled here so a late ack from before reset is dropped
          state      <= REQ;
          imem_req   <= 1'b1;
          fetch_addr <= pc;
          tcnt       <= '0;
        end
        REQ: begin
          if (!imem_req) begin
            // Re-issue gap: latch the newest pc (including a write landing this cycle)
            if (pc_write) pc <= pc_next;
            fetch_addr <= pc_write ? pc_next : pc;
            imem_req   <= 1'b1;
            tcnt       <= '0;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (pc_write) pc <= pc_next;
            if (redirect || pc_write) begin
              // Returned word belongs to a stale pc: drop it and refetch
              redirect <= 1'b0;
            end else begin
              ir          <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            // Request is in flight and cannot be withdrawn; remember the redirect
            if (pc_write) begin
              pc       <= pc_next;
              redirect <= 1'b1;
            end
            if (tcnt == TCNT_LAST) begin
              state       <= FAULT;
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (pc_write) begin
            pc          <= pc_next;
            fetch_addr  <= pc_next;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            redirect    <= 1'b0;
            tcnt        <= '0;
            state       <= REQ;
          end
        end
        FAULT: begin
          // Terminal until reset; pc_write has no effect
          imem_req <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        pc_write;
  logic        pc_source;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [31:0] imm_sext;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_target(branch_target),
    .instr        (instr),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm_sext     (imm_sext),
    .instr_valid  (instr_valid),
    .fetch_busy   (fetch_busy),
    .fetch_fault  (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_pc;
    logic [4:0]  exp_op;
    logic [2:0]  exp_rd;
    logic [2:0]  exp_rs1;
    logic [2:0]  exp_rs2;
    logic [31:0] exp_imm;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hold ack low for 'delay' cycles (checking the request stays put), then ack with data
  task automatic ack_after(input int delay, input logic [31:0] data, input logic [31:0] addr);
    for (int i = 0; i < delay; i++) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, addr);
      chk("valid_low_wait", {31'b0, instr_valid}, 32'd0);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic redirect_from_idle(input logic src);
    pc_write  = 1'b1;
    pc_source = src;
    step();
    pc_write  = 1'b0;
    pc_source = 1'b0;
  endtask

  initial begin
    int n;

    // data, delay, pc, opcode, rd, rs1, rs2, imm, branch_target
    vecs[0] = '{32'h1234_5678, 0, 32'h04, 5'd2,  3'd2, 3'd1, 3'd5, 32'h0000_5678, 32'h0001_59E4};
    vecs[1] = '{32'hFFFF_8000, 1, 32'h08, 5'd31, 3'd7, 3'd7, 3'd7, 32'hFFFF_8000, 32'hFFFE_0008};
    vecs[2] = '{32'h8000_7FFF, 3, 32'h0C, 5'd16, 3'd0, 3'd0, 3'd0, 32'h0000_7FFF, 32'h0002_0008};
    vecs[3] = '{32'h0000_FFFE, 0, 32'h10, 5'd0,  3'd0, 3'd0, 3'd0, 32'hFFFF_FFFE, 32'h0000_0008};

    reset_n    = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);

    // First fetch at RESET_PC, ack two cycles after req
    reset_n = 1'b1;
    step();
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_busy", {31'b0, fetch_busy}, 32'd1);
    ack_after(2, 32'h0A48_0005, 32'h0);
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_req", {31'b0, imem_req}, 32'd0);
    chk("t1_opcode", {27'b0, opcode}, 32'd1);
    chk("t1_rd", {29'b0, rd}, 32'd2);
    chk("t1_rs1", {29'b0, rs1}, 32'd2);
    // IR[20:18] of 0x0A48_0005 is 3'b010
    chk("t1_rs2", {29'b0, rs2}, 32'd2);
    chk("t1_imm", imm_sext, 32'd5);

    // Sequential fetches from IDLE with varied ack delay and field patterns
    for (int v = 0; v < 4; v++) begin
      redirect_from_idle(1'b0);
      chk("vec_pc", pc, vecs[v].exp_pc);
      chk("vec_req", {31'b0, imem_req}, 32'd1);
      chk("vec_addr", imem_addr, vecs[v].exp_pc);
      chk("vec_valid_drop", {31'b0, instr_valid}, 32'd0);
      ack_after(vecs[v].delay, vecs[v].rdata, vecs[v].exp_pc);
      chk("vec_valid", {31'b0, instr_valid}, 32'd1);
      chk("vec_ir", instr, vecs[v].rdata);
      chk("vec_opcode", {27'b0, opcode}, {27'b0, vecs[v].exp_op});
      chk("vec_rd", {29'b0, rd}, {29'b0, vecs[v].exp_rd});
      chk("vec_rs1", {29'b0, rs1}, {29'b0, vecs[v].exp_rs1});
      chk("vec_rs2", {29'b0, rs2}, {29'b0, vecs[v].exp_rs2});
      chk("vec_imm", imm_sext, vecs[v].exp_imm);
      chk("vec_bt", branch_target, vecs[v].exp_bt);
      chk("vec_pc4", pc_plus4, vecs[v].exp_pc + 32'd4);
    end

    // Backward branch from 0x10 with imm=-2 lands at 0x08
    redirect_from_idle(1'b1);
    chk("t2_pc", pc, 32'h08);
    chk("t2_addr", imem_addr, 32'h08);
    chk("t2_req", {31'b0, imem_req}, 32'd1);
    chk("t2_valid", {31'b0, instr_valid}, 32'd0);
    ack_after(1, 32'h0000_0006, 32'h08);
    chk("t2_valid_up", {31'b0, instr_valid}, 32'd1);

    // Branch 0x08 + 6*4 = 0x20, then sequential redirect before ack
    redirect_from_idle(1'b1);
    chk("t3_addr", imem_addr, 32'h20);
    step();
    pc_write  = 1'b1;
    pc_source = 1'b0;
    step();
    pc_write  = 1'b0;
    chk("t3_pc", pc, 32'h24);
    chk("t3_addr_hold", imem_addr, 32'h20);
    chk("t3_req_hold", {31'b0, imem_req}, 32'd1);
    ack_after(1, 32'hDEAD_BEEF, 32'h20);
    chk("t3_gap_req", {31'b0, imem_req}, 32'd0);
    chk("t3_discard", instr, 32'h0000_0006);
    chk("t3_valid_low", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t3_reissue_req", {31'b0, imem_req}, 32'd1);
    chk("t3_reissue_addr", imem_addr, 32'h24);
    ack_after(0, 32'h0000_0003, 32'h24);
    chk("t3_ir", instr, 32'h0000_0003);
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);

    // pc_write coincident with ack
    redirect_from_idle(1'b0);
    chk("t4_addr", imem_addr, 32'h28);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    pc_write   = 1'b1;
    pc_source  = 1'b0;
    step();
    imem_ack   = 1'b0;
    pc_write   = 1'b0;
    chk("t4_pc", pc, 32'h2C);
    chk("t4_ir_kept", instr, 32'h0000_0003);
    chk("t4_gap_req", {31'b0, imem_req}, 32'd0);
    chk("t4_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t4_reissue_req", {31'b0, imem_req}, 32'd1);
    chk("t4_reissue_addr", imem_addr, 32'h2C);
    ack_after(0, 32'h0000_0001, 32'h2C);
    chk("t4_ir", instr, 32'h0000_0001);

    // Ack timeout: 16 request cycles then fault
    redirect_from_idle(1'b0);
    chk("t5_addr", imem_addr, 32'h30);
    n = 0;
    while (!fetch_fault && n < 40) begin
      step();
      n++;
    end
    chk("t5_cycles", n, 32'd16);
    chk("t5_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t5_req", {31'b0, imem_req}, 32'd0);
    chk("t5_busy", {31'b0, fetch_busy}, 32'd0);
    pc_write = 1'b1;
    step();
    step();
    pc_write = 1'b0;
    chk("t5_pc_frozen", pc, 32'h30);
    chk("t5_fault_sticky", {31'b0, fetch_fault}, 32'd1);
    chk("t5_req_low", {31'b0, imem_req}, 32'd0);

    // Reset clears fault; then reach 0xFFFF_FFFC via imm=-1 and wrap
    reset_n = 1'b0;
    #1;
    chk("t6_fault_clr", {31'b0, fetch_fault}, 32'd0);
    chk("t6_pc_rst", pc, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    ack_after(0, 32'h0000_FFFF, 32'h0);
    chk("t6_bt", branch_target, 32'hFFFF_FFFC);
    redirect_from_idle(1'b1);
    chk("t6_pc_top", pc, 32'hFFFF_FFFC);
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    ack_after(0, 32'h0000_0010, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", pc_plus4, 32'h0);
    redirect_from_idle(1'b0);
    chk("t6_pc_wrap", pc, 32'h0);
    chk("t6_addr_wrap", imem_addr, 32'h0);
    ack_after(0, 32'h0000_0010, 32'h0);
    redirect_from_idle(1'b1);
    chk("t6_pc_40", pc, 32'h40);

    // Reset mid-REQ with an ack still pending across release
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    reset_n    = 1'b0;
    #1;
    chk("t6_mid_pc", pc, 32'h0);
    chk("t6_mid_req", {31'b0, imem_req}, 32'd0);
    chk("t6_mid_ir", instr, 32'h0);
    chk("t6_mid_busy", {31'b0, fetch_busy}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("t6_late_ack_ir", instr, 32'h0);
    chk("t6_late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_late_req", {31'b0, imem_req}, 32'd1);
    chk("t6_late_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
